// File: rtl/byte_accum_pkg.sv
// Shared types and constants for the byte_accumulator frame summer.
// Holds the FSM state encoding and the default widths used by the top level.
package byte_accum_pkg;

    localparam int DEFAULT_DATA_W  = 8;
    localparam int DEFAULT_COUNT_W = 4;

    // Clamp value used by the saturating-add build
    localparam logic [DEFAULT_DATA_W-1:0] SAT_VALUE = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/byte_accumulator_ripple_add8.sv
// Combinational ripple-carry adder: W-bit operands with carry-in and carry-out.
// Module ripple_add8 is the single add stage feeding the accumulator register.
module ripple_add8 #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);

    logic [W:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar g = 0; g < W; g++) begin : g_fa
        assign o_sum[g]  = i_a[g] ^ i_b[g] ^ w_c[g];
        assign w_c[g+1]  = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
    end

    assign o_cout = w_c[W];

endmodule

// File: rtl/byte_accumulator.sv
// Frame-based byte accumulator: sums a valid/ready byte stream per frame and
// presents sum, sticky carry and beat count. Define BYTE_ACCUM_SAT_EN for saturating add.
module byte_accumulator
    import byte_accum_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int COUNT_W = DEFAULT_COUNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_sum,
    output logic               out_carry,
    output logic [COUNT_W-1:0] out_count,
    output logic               out_cnt_ovf
);

    localparam logic [COUNT_W-1:0] L_CNT_MAX = '1;
`ifdef BYTE_ACCUM_SAT_EN
    localparam logic [DATA_W-1:0]  L_SAT     = '1;
`endif

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DATA_W-1:0]  r_acc;
    logic [DATA_W-1:0]  w_acc_nxt;
    logic               r_carry;
    logic               w_carry_nxt;
    logic [COUNT_W-1:0] r_count;
    logic [COUNT_W-1:0] w_count_nxt;
    logic               r_ovf;
    logic               w_ovf_nxt;

    logic [DATA_W-1:0]  w_add_a;
    logic [DATA_W-1:0]  w_add_sum;
    logic               w_add_cout;
    logic               w_in_ready;
    logic               w_accept;

    // Ready is held low throughout reset and whenever a result is waiting
    assign w_in_ready = rst_n && (r_state != HOLD);
    assign w_accept   = in_valid && w_in_ready;

    assign w_add_a = (r_state == ACCUM) ? r_acc : '0;

    ripple_add8 #(
        .W (DATA_W)
    ) u_add (
        .i_a    (w_add_a),
        .i_b    (in_data),
        .i_cin  (1'b0),
        .o_sum  (w_add_sum),
        .o_cout (w_add_cout)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_carry_nxt = r_carry;
        w_count_nxt = r_count;
        w_ovf_nxt   = r_ovf;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_acc_nxt   = w_add_sum;
                    w_carry_nxt = 1'b0;
                    w_count_nxt = COUNT_W'(1);
                    w_ovf_nxt   = 1'b0;
                    w_state_nxt = in_last ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (w_accept) begin
`ifdef BYTE_ACCUM_SAT_EN
                    w_acc_nxt   = w_add_cout ? L_SAT : w_add_sum;
`else
                    w_acc_nxt   = w_add_sum;
`endif
                    w_carry_nxt = r_carry | w_add_cout;
                    // Count saturates; the overflow flag records the lost beats
                    if (r_count == L_CNT_MAX) begin
                        w_ovf_nxt = 1'b1;
                    end else begin
                        w_count_nxt = r_count + COUNT_W'(1);
                    end
                    if (in_last) begin
                        w_state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                    w_acc_nxt   = '0;
                    w_carry_nxt = 1'b0;
                    w_count_nxt = '0;
                    w_ovf_nxt   = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_carry <= w_carry_nxt;
            r_count <= w_count_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = (r_state == HOLD);
    assign out_sum     = r_acc;
    assign out_carry   = r_carry;
    assign out_count   = r_count;
    assign out_cnt_ovf = r_ovf;

endmodule

// File: tb/tb_byte_accumulator.sv
// Directed bench for byte_accumulator: beats feed a reference model whose frame
// results are queued and compared when the DUT raises out_valid.
module tb_byte_accumulator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_sum;
    logic       out_carry;
    logic [3:0] out_count;
    logic       out_cnt_ovf;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] sum;
        logic       carry;
        logic [3:0] count;
        logic       ovf;
    } exp_t;

    exp_t sbQ[$];

    logic [7:0] mAcc;
    logic       mCarry;
    logic [3:0] mCount;
    logic       mOvf;
    logic       mInFrame = 1'b0;

    always #5 clk = ~clk;

    byte_accumulator #(
        .DATA_W  (8),
        .COUNT_W (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .out_carry   (out_carry),
        .out_count   (out_count),
        .out_cnt_ovf (out_cnt_ovf)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Reference model of one accepted beat
    task automatic modelBeat(input logic [7:0] data, input logic last);
        logic [8:0] sum9;
        if (!mInFrame) begin
            mAcc     = data;
            mCarry   = 1'b0;
            mCount   = 4'd1;
            mOvf     = 1'b0;
            mInFrame = 1'b1;
        end else begin
            sum9   = {1'b0, mAcc} + {1'b0, data};
            mCarry = mCarry | sum9[8];
`ifdef BYTE_ACCUM_SAT_EN
            mAcc   = sum9[8] ? 8'hFF : sum9[7:0];
`else
            mAcc   = sum9[7:0];
`endif
            if (mCount == 4'hF) mOvf = 1'b1;
            else                mCount = mCount + 4'd1;
        end
        if (last) begin
            sbQ.push_back('{sum: mAcc, carry: mCarry, count: mCount, ovf: mOvf});
            mInFrame = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic last);
        logic accepted;
        accepted = 1'b0;
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        for (int c = 0; c < 20 && !accepted; c++) begin
            if (in_ready === 1'b1) accepted = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'($urandom);
        checkOutput("beat_accept", {31'd0, accepted}, 32'd1);
        if (accepted) modelBeat(data, last);
    endtask

    task automatic idleCycles(input int n);
        for (int c = 0; c < n; c++) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            in_last  = 1'($urandom);
            @(posedge clk); #1;
        end
        in_last = 1'b0;
    endtask

    task automatic collectResult(input string tag);
        exp_t e;
        for (int c = 0; c < 20 && out_valid !== 1'b1; c++) begin
            @(posedge clk); #1;
        end
        checkOutput({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        if (sbQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_scoreboard observed=empty expected=entry", tag);
        end else begin
            e = sbQ.pop_front();
            checkOutput({tag, "_sum"},   {24'd0, out_sum},     {24'd0, e.sum});
            checkOutput({tag, "_carry"}, {31'd0, out_carry},   {31'd0, e.carry});
            checkOutput({tag, "_count"}, {28'd0, out_count},   {28'd0, e.count});
            checkOutput({tag, "_ovf"},   {31'd0, out_cnt_ovf}, {31'd0, e.ovf});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput({tag, "_drained"}, {31'd0, out_valid}, 32'd0);
        checkOutput({tag, "_ready"},   {31'd0, in_ready},  32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready",  {31'd0, in_ready},    32'd0);
        checkOutput("rst_out_valid", {31'd0, out_valid},   32'd0);
        checkOutput("rst_sum",       {24'd0, out_sum},     32'd0);
        checkOutput("rst_carry",     {31'd0, out_carry},   32'd0);
        checkOutput("rst_count",     {28'd0, out_count},   32'd0);
        checkOutput("rst_ovf",       {31'd0, out_cnt_ovf}, 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("rel_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        $display("[TB] basic frame");
        applyStimulus(8'h10, 1'b0);
        applyStimulus(8'h20, 1'b0);
        checkOutput("pre_last_valid", {31'd0, out_valid}, 32'd0);
        applyStimulus(8'h30, 1'b1);
        checkOutput("lat_valid", {31'd0, out_valid}, 32'd1);
        collectResult("basic");

        $display("[TB] carry frame");
        applyStimulus(8'hF0, 1'b0);
        applyStimulus(8'h20, 1'b1);
        collectResult("carry");

        $display("[TB] backpressure");
        applyStimulus(8'h33, 1'b0);
        applyStimulus(8'h44, 1'b1);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'($urandom);
            in_data  = 8'hAA;
            in_last  = 1'($urandom);
            #1;
            checkOutput("hold_valid",    {31'd0, out_valid}, 32'd1);
            checkOutput("hold_in_ready", {31'd0, in_ready},  32'd0);
            checkOutput("hold_sum",      {24'd0, out_sum},   32'h77);
            checkOutput("hold_count",    {28'd0, out_count}, 32'd2);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        collectResult("hold");
        applyStimulus(8'h01, 1'b1);
        collectResult("after_hold");

        $display("[TB] count overflow");
        for (int b = 0; b < 17; b++) begin
            applyStimulus(8'h01, (b == 16) ? 1'b1 : 1'b0);
        end
        collectResult("ovf");

        $display("[TB] reset mid-frame");
        applyStimulus(8'h11, 1'b0);
        applyStimulus(8'h22, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("midrst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midrst_sum",   {24'd0, out_sum},   32'd0);
        checkOutput("midrst_count", {28'd0, out_count}, 32'd0);
        rst_n    = 1'b1;
        mInFrame = 1'b0;
        #1;
        checkOutput("midrst_rel_ready", {31'd0, in_ready}, 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checkOutput("midrst_no_result", {31'd0, out_valid}, 32'd0);
        end
        applyStimulus(8'h05, 1'b1);
        collectResult("after_rst");

        $display("[TB] gapped frame");
        for (int b = 1; b <= 4; b++) begin
            idleCycles(int'($urandom_range(0, 3)));
            applyStimulus(8'(b), (b == 4) ? 1'b1 : 1'b0);
        end
        collectResult("gaps");

        checkOutput("sb_drained", sbQ.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
